// File: rtl/dac_pkg.sv
// ============================================================================
// Module : dac_pkg
// Brief  : Shared FSM encoding and fixed-point constants for the DAC SPI formatter.
//          Rounding offset depends on DAC_ROUND_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic int mid_scale(input int n_dac);
        return 1 << (n_dac - 1);
    endfunction

    // Shifts the [-0.5,+0.5) input range onto [0,1) before code extraction
    function automatic int offset(input int decimal);
        return 1 << (decimal - 1);
    endfunction

    function automatic int round_add(input int decimal, input int n_dac);
`ifdef DAC_ROUND_EN
        return 1 << (decimal - n_dac - 1);
`else
        return 0;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_fixed_to_code.sv
// ============================================================================
// Module : dac_fixed_to_code
// Brief  : Combinational signed fixed-point to offset-binary DAC code with clamp.
//          Rounding enabled by DAC_ROUND_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dac_fixed_to_code
    import dac_pkg::*;
#(
    parameter int MAGNITUD = 8,
    parameter int DECIMAL  = 14,
    parameter int N_DAC    = 12,
    parameter int N        = MAGNITUD + DECIMAL + 1
) (
    input  logic [N-1:0]     data_in,
    output logic [N_DAC-1:0] code,
    output logic             sat
);

    localparam logic [N:0] c_add = (N+1)'(offset(DECIMAL) + round_add(DECIMAL, N_DAC));

    logic [N:0] w_y;
    logic       w_unused_lsbs;

    // One extra bit of headroom keeps offset plus rounding free of overflow
    assign w_y           = {data_in[N-1], data_in} + c_add;
    assign w_unused_lsbs = ^w_y[DECIMAL-N_DAC-1:0];

    always_comb begin
        code = w_y[DECIMAL-1 -: N_DAC];
        sat  = 1'b0;
        if (w_y[N]) begin
            code = '0;
            sat  = 1'b1;
        end else if (|w_y[N-1:DECIMAL]) begin
            code = '1;
            sat  = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dac_spi_formatter.sv
// ============================================================================
// Module : dac_spi_formatter
// Brief  : Registers converted DAC codes and serialises each one as an SPI frame.
//          Optional rounding via DAC_ROUND_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dac_spi_formatter
    import dac_pkg::*;
#(
    parameter int MAGNITUD   = 8,
    parameter int DECIMAL    = 14,
    parameter int N          = MAGNITUD + DECIMAL + 1,
    parameter int N_DAC      = 12,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     data_in,
    input  logic             data_valid,
    output logic             ready,
    output logic [N_DAC-1:0] dac_code,
    output logic             sat_flag,
    output logic             sclk,
    output logic             sync_n,
    output logic             sdata
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TOG_W = $clog2(2 * FRAME_BITS);
    localparam logic [N_DAC-1:0] c_mid   = N_DAC'(mid_scale(N_DAC));
    localparam logic [DIV_W-1:0] c_div_l = DIV_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] c_tog_l = TOG_W'(2 * FRAME_BITS - 1);

    state_t                  r_state, w_state_nxt;
    logic [DIV_W-1:0]        r_div;
    logic [TOG_W-1:0]        r_tog;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [FRAME_BITS-1:0]   w_frame;
    logic [FRAME_BITS-1:0]   w_shift_nxt;
    logic [N_DAC-1:0]        r_dac_code;
    logic [N_DAC-1:0]        w_code;
    logic                    r_sat, w_sat;
    logic                    r_sclk, r_sync_n, r_sdata;
    logic                    w_div_done, w_last_tog;

    dac_fixed_to_code #(
        .MAGNITUD (MAGNITUD),
        .DECIMAL  (DECIMAL),
        .N_DAC    (N_DAC),
        .N        (N)
    ) u_conv (
        .data_in  (data_in),
        .code     (w_code),
        .sat      (w_sat)
    );

    assign w_frame     = FRAME_BITS'(r_dac_code);
    assign w_shift_nxt = r_shift << 1;
    assign w_div_done  = (r_div == c_div_l);
    assign w_last_tog  = (r_tog == c_tog_l);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (data_valid) w_state_nxt = ST_LOAD;
            end
            ST_LOAD:  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_div_done && w_last_tog) w_state_nxt = ST_GAP;
            ST_GAP:   if (w_div_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= '0;
            r_tog      <= '0;
            r_shift    <= '0;
            r_dac_code <= c_mid;
            r_sat      <= 1'b0;
            r_sclk     <= 1'b1;
            r_sync_n   <= 1'b1;
            r_sdata    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_div <= '0;
                    r_tog <= '0;
                    if (data_valid) begin
                        r_dac_code <= w_code;
                        r_sat      <= w_sat;
                    end
                end
                ST_LOAD: begin
                    r_shift  <= w_frame;
                    r_sync_n <= 1'b0;
                    r_sdata  <= w_frame[FRAME_BITS-1];
                end
                ST_SHIFT: begin
                    if (w_div_done) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        r_tog  <= r_tog + 1'b1;
                        // Advance data on the rising edge so it is stable at the DAC's falling-edge sample
                        if (!r_sclk) begin
                            r_shift <= w_shift_nxt;
                            r_sdata <= w_shift_nxt[FRAME_BITS-1];
                        end
                        if (w_last_tog) r_sync_n <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_sdata <= 1'b0;
                    r_div   <= w_div_done ? '0 : r_div + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dac_code = r_dac_code;
    assign sat_flag = r_sat;
    assign sclk     = r_sclk;
    assign sync_n   = r_sync_n;
    assign sdata    = r_sdata;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_formatter.sv
// ============================================================================
// Module : tb_dac_spi_formatter
// Brief  : Self-checking bench for dac_spi_formatter (honours DAC_ROUND_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dac_spi_formatter;

    localparam int N          = 23;
    localparam int N_DAC      = 12;
    localparam int FRAME_BITS = 16;
    localparam int CLK_DIV    = 4;
`ifdef DAC_ROUND_EN
    localparam int RND = 2;
`else
    localparam int RND = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     data_in = '0;
    logic             data_valid = 1'b0;
    logic             ready, sat_flag, sclk, sync_n, sdata;
    logic [N_DAC-1:0] dac_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] sb_code[$];
    logic        sb_bit[$];

    dac_spi_formatter dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .dac_code   (dac_code),
        .sat_flag   (sat_flag),
        .sclk       (sclk),
        .sync_n     (sync_n),
        .sdata      (sdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference mapping: {sat, code}
    function automatic logic [12:0] model(input int x);
        int y;
        y = x + 8192 + RND;
        if (y < 0)      return {1'b1, 12'h000};
        if (y >= 16384) return {1'b1, 12'hFFF};
        return {1'b0, 12'(y >>> 2)};
    endfunction

    task automatic send(input int x);
        @(negedge clk);
        data_in    = N'(x);
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready timeout: got %b want 1", tag, ready);
        end
    endtask

    task automatic push_frame(input logic [15:0] code);
        logic [FRAME_BITS-1:0] fr;
        fr = code;
        for (int i = FRAME_BITS - 1; i >= 0; i--) sb_bit.push_back(fr[i]);
    endtask

    task automatic capture_frame(input int inject_at, input int inject_x,
                                 output int falls, output int low, output int gap,
                                 output logic rdy_at_inject);
        int   cyc;
        logic prev;
        logic exp;
        bit   seen_low, done;
        cyc = 0; prev = 1'b1; seen_low = 0; done = 0;
        falls = 0; low = 0; gap = 0; rdy_at_inject = 1'bx;
        while (cyc < 400 && !done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == inject_at) begin
                rdy_at_inject = ready;
                data_in       = N'(inject_x);
                data_valid    = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            if (sync_n === 1'b0) begin
                low++;
                seen_low = 1;
                if (prev === 1'b1 && sclk === 1'b0) begin
                    falls++;
                    if (sb_bit.size() > 0) begin
                        exp = sb_bit.pop_front();
                        n_checks++;
                        if (sdata !== exp) begin
                            n_fail++;
                            $display("FAIL sdata bit %0d: got %b want %b", falls, sdata, exp);
                        end
                    end
                end
            end else if (seen_low) begin
                if (ready === 1'b1) done = 1;
                else gap++;
            end
            prev = sclk;
        end
        data_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL frame_end: got timeout want frame completion");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ready, sync_n, sclk, sdata, sat_flag, dac_code} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h800}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b sync_n=%b sclk=%b sdata=%b sat=%b code=%h want 1 1 1 0 0 800",
                     ready, sync_n, sclk, sdata, sat_flag, dac_code);
        end
    endtask

    task automatic test_mapping();
        int xs[10] = '{0, 4096, 8192, -8192, -9830, 2, 8191, -1, 2416, -2000000};
        logic [12:0] exp;
        foreach (xs[i]) begin
            wait_ready("mapping");
            sb_code.push_back(model(xs[i]));
            send(xs[i]);
            exp = sb_code.pop_front();
            n_checks++;
            if ({sat_flag, dac_code} !== exp) begin
                n_fail++;
                $display("FAIL map x=%0d: got sat=%b code=%h want sat=%b code=%h",
                         xs[i], sat_flag, dac_code, exp[12], exp[11:0]);
            end
        end
    endtask

    task automatic test_frame();
        int falls, low, gap;
        logic r;
        logic [12:0] exp;
        wait_ready("frame");
        sb_code.push_back(model(2416));
        push_frame(16'h0A5C);
        send(2416);
        exp = sb_code.pop_front();
        n_checks++;
        if ({sat_flag, dac_code} !== exp) begin
            n_fail++;
            $display("FAIL frame_code: got %h want %h", dac_code, exp[11:0]);
        end
        capture_frame(0, 0, falls, low, gap, r);
        n_checks++;
        if (falls != FRAME_BITS) begin
            n_fail++;
            $display("FAIL frame_falls: got %0d want %0d", falls, FRAME_BITS);
        end
        n_checks++;
        if (low != 2 * CLK_DIV * FRAME_BITS) begin
            n_fail++;
            $display("FAIL sync_low_cycles: got %0d want %0d", low, 2 * CLK_DIV * FRAME_BITS);
        end
        n_checks++;
        if (gap != CLK_DIV) begin
            n_fail++;
            $display("FAIL gap_cycles: got %0d want %0d", gap, CLK_DIV);
        end
        n_checks++;
        if (sb_bit.size() != 0) begin
            n_fail++;
            $display("FAIL frame_bits_left: got %0d want 0", sb_bit.size());
        end
    endtask

    task automatic test_drop();
        int falls, low, gap;
        logic r;
        wait_ready("drop");
        push_frame(16'h0A5C);
        send(2416);
        capture_frame(10, 0, falls, low, gap, r);
        n_checks++;
        if (r !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_ready: got %b want 0", r);
        end
        n_checks++;
        if (falls != FRAME_BITS) begin
            n_fail++;
            $display("FAIL drop_falls: got %0d want %0d", falls, FRAME_BITS);
        end
        @(negedge clk);
        n_checks++;
        if (dac_code !== 12'hA5C || sync_n !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_code: got code=%h sync_n=%b want code=a5c sync_n=1", dac_code, sync_n);
        end
    endtask

    task automatic test_reset_midframe();
        wait_ready("midframe");
        send(8192);
        repeat (49) @(posedge clk);
        #1;
        n_checks++;
        if (sync_n !== 1'b0 || sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_active: got sync_n=%b sat=%b want 0 1", sync_n, sat_flag);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({sync_n, sclk, sat_flag, dac_code} !== {1'b1, 1'b1, 1'b0, 12'h800}) begin
            n_fail++;
            $display("FAIL midframe_abort: got sync_n=%b sclk=%b sat=%b code=%h want 1 1 0 800",
                     sync_n, sclk, sat_flag, dac_code);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || sync_n !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: got ready=%b sync_n=%b want 1 1", ready, sync_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        int xs[3] = '{4096, -4096, 6000};
        foreach (xs[i]) begin
            sb_code.push_back(model(xs[i]));
            wait_ready("b2b");
            send(xs[i]);
            exp = sb_code.pop_front();
            n_checks++;
            if ({sat_flag, dac_code} !== exp) begin
                n_fail++;
                $display("FAIL b2b x=%0d: got %h want %h", xs[i], dac_code, exp[11:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_frame();
        test_drop();
        test_reset_midframe();
        test_back_to_back();
        wait_ready("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
